// File: rtl/pipeline_skid_reg.sv
// Two-entry valid/ready register slice: registered forward path, in_ready straight from a flop.
// Optional perf counters (stall_cnt, skid_cnt) are built when PIPELINE_SKID_PERF_EN is defined.
module pipeline_skid_reg #(
    parameter int WIDTH = 8
`ifdef PIPELINE_SKID_PERF_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPELINE_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] skid_cnt
`endif
);

    // Encoding is {skid_valid, out_valid}, so both handshake outputs are raw flop bits.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             in_fire;
    logic             out_fire;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments with async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (in_fire) state_nxt = BUSY;
            BUSY: begin
                if (in_fire && !out_ready) state_nxt = FULL;
                else if (!in_fire && out_fire) state_nxt = EMPTY;
            end
            FULL:    if (out_fire) state_nxt = BUSY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = state[0];
        in_ready  = ~state[1];
    end

    // Payload steering: skid only catches the beat that arrives while main is stalled.
    always_comb begin
        load_main_in   = in_fire && ((state == EMPTY) || ((state == BUSY) && out_ready));
        load_skid      = in_fire && (state == BUSY) && !out_ready;
        load_main_skid = (state == FULL) && out_ready;
    end

    // NOTE: payload registers are reset too, so out_data reads a defined 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data <= '0;
        end else if (load_main_skid) begin
            main_data <= skid_data;
        end else if (load_main_in) begin
            main_data <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data <= '0;
        end else if (load_skid) begin
            skid_data <= in_data;
        end
    end

    assign out_data = main_data;

`ifdef PIPELINE_SKID_PERF_EN
    logic stall_ev;

    assign stall_ev = out_valid && !out_ready;

    // Saturating counters: hold at all-ones rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            skid_cnt  <= '0;
        end else begin
            if (stall_ev && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (load_skid && (skid_cnt != '1)) skid_cnt <= skid_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
